// File: rtl/ff_cmd_arbiter.sv
// ============================================================================
// Module      : ff_cmd_arbiter
// Description : Two-requester round-robin arbiter and sequencer for a bank of
//               set/toggle/clear/hold bit cells. Grants at most one masked
//               command per cycle, owns the bank state, and reports
//               completion and contention (saturating stall counter).
//               Optional feature macro: FFARB_LOCK_EN (lock states LOCK0 and
//               LOCK1 that give one requester exclusive ownership).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_cmd_arbiter #(
   parameter int WIDTH   = 8,
   parameter int STALL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   // requester 0
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [1:0]         req0_op,
   input  logic [WIDTH-1:0]   req0_mask,
   input  logic               req0_lock,
   // requester 1
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [1:0]         req1_op,
   input  logic [WIDTH-1:0]   req1_mask,
   input  logic               req1_lock,
   // bank state and status
   output logic [WIDTH-1:0]   q,
   output logic               done,
   output logic               done_id,
   output logic [STALL_W-1:0] stall_cnt
);

   // Command encoding {b1,b2}
   localparam logic [1:0] OP_SET    = 2'b11;
   localparam logic [1:0] OP_TOGGLE = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b01;

   localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
   localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_t;

   state_t             state;
   logic               last;       // ID of the most recently granted requester
   logic               gnt0;
   logic               gnt1;
   logic               accept;
   logic               accept_id;
   logic               sel_lock;
   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_mask;
   logic [WIDTH-1:0]   q_next;
   logic               stall_evt;

   // Grant selection: lock owner only while locked, otherwise round-robin
   // where a lone valid requester always wins and a tie goes to the one
   // that was not granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         ST_LOCK0: gnt0 = req0_valid;
         ST_LOCK1: gnt1 = req1_valid;
         default: begin
            if (req0_valid && req1_valid) begin
               gnt0 = last;
               gnt1 = ~last;
            end else begin
               gnt0 = req0_valid;
               gnt1 = req1_valid;
            end
         end
      endcase
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign accept     = gnt0 | gnt1;
   assign accept_id  = gnt1;

   // A requester that is valid but not granted this cycle counts as a stall.
   assign stall_evt = (req0_valid & ~gnt0) | (req1_valid & ~gnt1);

   // Steer the granted command onto the shared bank; a zero mask means no
   // cell is touched when nothing is accepted.
   always_comb begin
      sel_op   = 2'b00;
      sel_mask = '0;
      sel_lock = 1'b0;
      if (gnt0) begin
         sel_op   = req0_op;
         sel_mask = req0_mask;
         sel_lock = req0_lock;
      end else if (gnt1) begin
         sel_op   = req1_op;
         sel_mask = req1_mask;
         sel_lock = req1_lock;
      end
   end

   // Next value of one bit cell for a given command and select.
   function automatic logic cell_next(input logic cur, input logic [1:0] op,
                                      input logic sel);
      logic nxt;
      nxt = cur;
      if (sel) begin
         case (op)
            OP_SET:    nxt = 1'b1;
            OP_TOGGLE: nxt = ~cur;
            OP_CLEAR:  nxt = 1'b0;
            default:   nxt = cur;
         endcase
      end
      return nxt;
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign q_next[i] = cell_next(q[i], sel_op, sel_mask[i]);
   end

`ifdef FFARB_LOCK_EN
   // Arbitration FSM: round-robin pointer plus lock ownership transitions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         last  <= 1'b1;
      end else begin
         if (accept) begin
            last <= accept_id;
         end
         case (state)
            ST_IDLE: begin
               if (accept && sel_lock) begin
                  state <= accept_id ? ST_LOCK1 : ST_LOCK0;
               end
            end
            ST_LOCK0: begin
               if (gnt0 && !sel_lock) begin
                  state <= ST_IDLE;
               end
            end
            ST_LOCK1: begin
               if (gnt1 && !sel_lock) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`else
   // Lock inputs are ignored in the pure round-robin build.
   logic unused_lock;
   assign unused_lock = req0_lock | req1_lock | sel_lock;

   // Arbitration FSM: round-robin pointer only; the state never leaves IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         last  <= 1'b1;
      end else begin
         state <= ST_IDLE;
         if (accept) begin
            last <= accept_id;
         end
      end
   end
`endif

   // Bank state, completion pulse and saturating stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q         <= '0;
         done      <= 1'b0;
         done_id   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         q    <= q_next;
         done <= accept;
         if (accept) begin
            done_id <= accept_id;
         end
         if (stall_evt && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + STALL_ONE;
         end
      end
   end

endmodule

`default_nettype wire
